// File: rtl/arb4_rr_onehot.sv
// 4-requester round-robin arbiter with grant hold; registered one-hot grant for a 4-to-2 encoder.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module arb4_rr_onehot #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
    $error("arb4_rr_onehot: illegal HOLD_MAX/CNT_W combination");
  end

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_valid_q;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner;
  logic [2:0] idle_pick, hand_pick;
  logic       release_w;

  // Returns {found, index} of the first set bit scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = p + 2'(k - 1);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             forced;
`endif

  always_comb begin
    owner = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt_q[i]) owner = i[1:0];
    end

    idle_pick = rr_pick(req, ptr_q);
    hand_pick = rr_pick(req & ~gnt_q, owner + 2'd1);

`ifdef ARB_TIMEOUT_EN
    forced    = req[owner] && (cnt_q == CNT_W'(HOLD_MAX));
    release_w = ~req[owner] | forced;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`else
    release_w = ~req[owner];
`endif

    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          gnt_d   = 4'b0001 << idle_pick[1:0];
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        if (release_w) begin
          // Handover decision uses the rotated pointer with the old owner masked.
          ptr_d = owner + 2'd1;
`ifdef ARB_TIMEOUT_EN
          timeout_d = forced;
          cnt_d     = CNT_W'(1);
`endif
          if (hand_pick[2]) begin
            gnt_d = 4'b0001 << hand_pick[1:0];
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_rr_onehot.sv
// Bench for arb4_rr_onehot: directed literal checks plus randomized traffic against a behavioural model.
module tb_arb4_rr_onehot;

  localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;

  bit         lit_en = 1'b0;
  logic [3:0] lit_gnt = 4'b0000;
  logic       lit_to = 1'b0;
  string      lit_name = "";

  always #5 clk = ~clk;

  arb4_rr_onehot #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  typedef struct {
    int owner;  // -1 when nobody holds the grant
    int ptr;
    int cnt;
    bit to;
  } model_t;

  model_t m = '{owner: -1, ptr: 0, cnt: 0, to: 1'b0};

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic model_t model_step(input model_t s, input logic [3:0] r, input logic rs);
    model_t n;
    logic [3:0] masked;
    bit forced;
    n = s;
    n.to = 1'b0;
    if (rs) begin
      n.owner = -1;
      n.ptr = 0;
      n.cnt = 0;
    end else if (s.owner < 0) begin
      if (r != 4'b0000) begin
        n.owner = scan(r, s.ptr);
        n.cnt = 1;
      end
    end else begin
      forced = TO_EN && r[s.owner] && (s.cnt == HM);
      if (!r[s.owner] || forced) begin
        n.ptr = (s.owner + 1) % 4;
        masked = r;
        masked[s.owner] = 1'b0;
        n.owner = scan(masked, n.ptr);
        n.cnt = 1;
        n.to = forced;
      end else if (s.cnt < 255) begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, req, rst);

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    if (run_cmp) begin
      eg = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
      chk("model_gnt", gnt, eg);
      chk("model_gnt_valid", {3'b000, gnt_valid}, {3'b000, (eg != 4'b0000)});
      chk("model_timeout", {3'b000, timeout}, {3'b000, m.to});
      chk("onehot_invariant", {3'b000, ($countones(gnt) <= 1)}, 4'b0001);
      if (lit_en) begin
        chk({lit_name, "_gnt"}, gnt, lit_gnt);
        chk({lit_name, "_valid"}, {3'b000, gnt_valid}, {3'b000, (lit_gnt != 4'b0000)});
        chk({lit_name, "_timeout"}, {3'b000, timeout}, {3'b000, lit_to});
      end
    end
  end

  // Drive one cycle of stimulus; the literal expectation applies to the outputs after that edge.
  task automatic cyc(input logic [3:0] r, input logic rs, input bit c,
                     input logic [3:0] eg, input logic et, input string nm);
    req = r;
    rst = rs;
    lit_en = 1'b0;
    @(posedge clk);
    #1;
    lit_en = c;
    lit_gnt = eg;
    lit_to = et;
    lit_name = nm;
    @(negedge clk);
    #1;
  endtask

  logic [3:0] to_g[10];
  logic       to_t[10];
  logic [3:0] r;
  logic       rs;

  initial begin
    run_cmp = 1'b1;

    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, "reset0");
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, "reset1");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "idle0");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "idle1");

    cyc(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, "single0");
    cyc(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, "single1");
    cyc(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, "single2");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "single_drop");

    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, "rot_reset");
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, "rot_g0a");
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, "rot_g0b");
    cyc(4'b1110, 1'b0, 1'b1, 4'b0010, 1'b0, "rot_g1a");
    cyc(4'b1111, 1'b0, 1'b1, 4'b0010, 1'b0, "rot_g1b");
    cyc(4'b1101, 1'b0, 1'b1, 4'b0100, 1'b0, "rot_g2a");
    cyc(4'b1111, 1'b0, 1'b1, 4'b0100, 1'b0, "rot_g2b");
    cyc(4'b1011, 1'b0, 1'b1, 4'b1000, 1'b0, "rot_g3a");
    cyc(4'b1111, 1'b0, 1'b1, 4'b1000, 1'b0, "rot_g3b");
    cyc(4'b0111, 1'b0, 1'b1, 4'b0001, 1'b0, "rot_wrap");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "rot_end");

    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, "pri_reset");
    cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "pri_own2");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "pri_rel2");
    cyc(4'b0101, 1'b0, 1'b1, 4'b0001, 1'b0, "pri_scan30");
    cyc(4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0, "pri_own3");
    cyc(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, "pri_ptr_wrap");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "pri_end");

    cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "mid_own2");
    cyc(4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, "mid_reset");
    cyc(4'b0110, 1'b0, 1'b1, 4'b0010, 1'b0, "mid_after");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "mid_end");

    if (TO_EN) begin
      to_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1};
      to_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    end else begin
      to_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      to_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, "hold_reset");
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0011, 1'b0, 1'b1, to_g[i], to_t[i], $sformatf("hold%0d", i));
    end

    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      r = r ^ 4'($urandom & $urandom);
      if ($urandom_range(0, 99) == 0) r = 4'b1111;
      rs = ($urandom_range(0, 63) == 0);
      cyc(r, rs, 1'b0, 4'b0000, 1'b0, "rand");
    end

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
